// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared FSM state type and counter sizing for shift_add_multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int N_BITS_DEFAULT = 4;
  localparam int CNT_W          = $clog2(N_BITS_DEFAULT + 1);

  // Iteration counter must reach N_BITS itself, hence the +1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mult_datapath.sv
// rtl/mult_datapath.sv - accumulator, shifted multiplicand/multiplier and iteration counter
module mult_datapath
  import mult_pkg::*;
#(
  parameter int N_BITS = 4,
  parameter int CW     = cnt_width(N_BITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [N_BITS-1:0]     x,
  input  logic [N_BITS-1:0]     y,
  output logic [2*N_BITS-1:0]   acc,
  output logic [CW-1:0]         cnt
);

  logic [2*N_BITS-1:0] mcand;
  logic [N_BITS-1:0]   mplr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      cnt   <= '0;
    end else if (load) begin
      acc   <= '0;
      mcand <= {{N_BITS{1'b0}}, x};
      mplr  <= y;
      cnt   <= '0;
    end else if (step) begin
      if (mplr[0]) acc <= acc + mcand;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential radix-2 shift-and-add unsigned multiplier
// Optional MULT_ZERO_SKIP_EN: zero operands finish without entering RUN.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int N_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N_BITS-1:0]     x,
  input  logic [N_BITS-1:0]     y,
  output logic [2*N_BITS-1:0]   s,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = cnt_width(N_BITS);

  mult_state_t         state;
  logic [2*N_BITS-1:0] acc;
  logic [CW-1:0]       cnt;
  logic                load;
  logic                step;
  logic                last;
  logic                zero_skip;

  assign last = (cnt == CW'(N_BITS));
  assign load = (state == IDLE) && start;
  assign step = (state == RUN) && !last;

`ifdef MULT_ZERO_SKIP_EN
  assign zero_skip = (x == '0) || (y == '0);
`else
  assign zero_skip = 1'b0;
`endif

  mult_datapath #(.N_BITS(N_BITS), .CW(CW)) u_datapath (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .x     (x),
    .y     (y),
    .acc   (acc),
    .cnt   (cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      s     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (zero_skip) begin
              s     <= '0;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (last) begin
            s     <= acc;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          // A zero-skip entry arrives with done low; raise it for one cycle before leaving.
          if (!done) begin
            done <= 1'b1;
          end else begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - scoreboard bench for shift_add_multiplier (honours MULT_ZERO_SKIP_EN)
module tb_shift_add_multiplier;

  localparam int N = 4;
  localparam int W = 2 * N;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] x     = '0;
  logic [N-1:0] y     = '0;
  logic [W-1:0] s;
  logic         busy;
  logic         done;

  int total     = 0;
  int bad       = 0;
  int cyc       = 0;
  int next_free = 0;

  typedef struct {
    logic [63:0] prod;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t got;

  shift_add_multiplier #(.N_BITS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .s     (s),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Edges from accepted start to the done pulse.
  function automatic int latency(input int a, input int b);
`ifdef MULT_ZERO_SKIP_EN
    if (a == 0 || b == 0) return 1;
`endif
    return N + 1;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        got = sb.pop_front();
        check("product", s, got.prod);
        check("done_cycle", cyc, got.done_cyc);
        check("busy_at_done", busy, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_free();
    while (cyc < next_free) tick();
  endtask

  task automatic issue(input int a, input int b);
    int dc;
    wait_free();
    start = 1'b1;
    x     = N'(a);
    y     = N'(b);
    dc    = cyc + 1 + latency(a, b);
    sb.push_back('{prod: 64'(a * b), done_cyc: dc});
    next_free = dc + 1;
    tick();
    start = 1'b0;
    x     = N'($urandom);
    y     = N'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    wait_free();
  endtask

  task automatic back_to_back();
    int a[3];
    int b[3];
    int acc_cyc;
    int dc;
    a = '{6, 15, 12};
    b = '{12, 15, 11};
    wait_free();
    start   = 1'b1;
    x       = N'(a[0]);
    y       = N'(b[0]);
    acc_cyc = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      dc = acc_cyc + latency(a[i], b[i]);
      sb.push_back('{prod: 64'(a[i] * b[i]), done_cyc: dc});
      while (cyc < acc_cyc) tick();
      if (i < 2) begin
        x = N'(a[i + 1]);
        y = N'(b[i + 1]);
      end else begin
        start = 1'b0;
      end
      acc_cyc = dc + 2;
    end
    next_free = dc + 1;
    drain();
  endtask

  initial begin
    logic saw_busy;
    int   a;
    int   b;

    // Reset, then idle with no start.
    #3;
    check("reset_s", s, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("idle_s", s, 0);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    // Single operation and result hold.
    issue(8, 5);
    drain();
    repeat (3) tick();
    check("hold_s", s, 40);

    back_to_back();

    // start pulsed during RUN with other operands must be ignored.
    issue(9, 7);
    tick();
    start = 1'b1;
    x     = 4'd3;
    y     = 4'd2;
    tick();
    start = 1'b0;
    drain();

    // Reset in the middle of a run.
    issue(7, 9);
    tick();
    rst_n = 1'b0;
    #1;
    check("midreset_s", s, 0);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    sb.delete();
    next_free = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    issue(3, 3);
    drain();

    // Zero operand.
    saw_busy = 1'b0;
    issue(0, 13);
    for (int n = 0; n < 20 && sb.size() != 0; n++) begin
      if (busy) saw_busy = 1'b1;
      tick();
    end
`ifdef MULT_ZERO_SKIP_EN
    check("zero_busy_seen", saw_busy, 0);
`else
    check("zero_busy_seen", saw_busy, 1);
`endif
    drain();

    // Extreme operand.
    issue(15, 15);
    drain();

    // Randomized operations with random gaps.
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, 15));
      b = int'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = 0;
      if ($urandom_range(0, 7) == 0) b = 0;
      issue(a, b);
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
